// File: rtl/vram_pkg.sv
// vram_pkg: shared types and defaults for the VRAM arbiter
package vram_pkg;
   typedef enum logic {CLR_IDLE, CLR_RUN} clear_state_t;
   typedef enum logic [1:0] {SLOT_NONE, SLOT_RD, SLOT_CLR, SLOT_WR} slot_t;
   localparam int DEF_CELLS = 2400;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: host write queue, pointer pair with wrap bit for full/empty
module vram_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0] wp_q, wp_d, rp_q, rp_d;
   assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign empty = wp_q == rp_q;
   assign dout  = mem_q[rp_q[AW-1:0]];
   always_comb begin
      wp_d = wp_q + (AW+1)'(push && !full);
      rp_d = rp_q + (AW+1)'(pop && !empty);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   always_ff @(posedge clk)
      if (push && !full) mem_q[wp_q[AW-1:0]] <= din;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: one RAM port shared by renderer reads, screen clear and queued host writes
module vram_arbiter import vram_pkg::*; #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 8,
   parameter int CELLS      = DEF_CELLS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_pix_clk,
   input  logic              i_reset_n,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_clear_start,
   input  logic [DATA_W-1:0] i_clear_data,
   output logic              o_clear_busy,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_we,
   input  logic [DATA_W-1:0] i_mem_rdata
);
   clear_state_t st_q, st_d;
   slot_t slot;
   logic [ADDR_W:0] caddr_q, caddr_d;
   logic [DATA_W-1:0] fill_q, fill_d, rd_data_q, rd_data_d, wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic we_d, we_q, rd_pend_q, rd_valid_q, live_q;
   logic full, empty;
   logic [ADDR_W+DATA_W-1:0] f_dout;
   // ready stays low until the first edge after reset release
   assign o_wr_ready   = live_q && !full;
   assign o_clear_busy = st_q == CLR_RUN;
   assign o_rd_data    = rd_data_q;
   assign o_rd_valid   = rd_valid_q;
   assign o_mem_addr   = addr_q;
   assign o_mem_wdata  = wdata_q;
   assign o_mem_we     = we_q;
   vram_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W+DATA_W)) u_fifo (
      .clk(i_pix_clk), .rst_n(i_reset_n),
      .push(i_wr_valid && o_wr_ready), .din({i_wr_addr, i_wr_data}),
      .pop(slot == SLOT_WR), .dout(f_dout), .full(full), .empty(empty)
   );
   always_comb begin
      slot = i_rd_req ? SLOT_RD : st_q == CLR_RUN ? SLOT_CLR : !empty ? SLOT_WR : SLOT_NONE;
      addr_d = slot == SLOT_RD ? i_rd_addr : slot == SLOT_CLR ? caddr_q[ADDR_W-1:0] :
               slot == SLOT_WR ? f_dout[ADDR_W+DATA_W-1:DATA_W] : addr_q;
      wdata_d = slot == SLOT_CLR ? fill_q : slot == SLOT_WR ? f_dout[DATA_W-1:0] : wdata_q;
      we_d = slot == SLOT_CLR || slot == SLOT_WR;
      caddr_d = st_q == CLR_IDLE ? '0 : caddr_q + (ADDR_W+1)'(slot == SLOT_CLR);
      st_d = st_q == CLR_IDLE ? (i_clear_start ? CLR_RUN : CLR_IDLE) :
             (slot == SLOT_CLR && caddr_q == (ADDR_W+1)'(CELLS-1)) ? CLR_IDLE : CLR_RUN;
      fill_d = (st_q == CLR_IDLE && i_clear_start) ? i_clear_data : fill_q;
      rd_data_d = rd_pend_q ? i_mem_rdata : rd_data_q;
   end
   always_ff @(posedge i_pix_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         st_q       <= CLR_IDLE;
         caddr_q    <= '0;
         fill_q     <= '0;
         rd_data_q  <= '0;
         wdata_q    <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         live_q     <= 1'b0;
      end else begin
         st_q       <= st_d;
         caddr_q    <= caddr_d;
         fill_q     <= fill_d;
         rd_data_q  <= rd_data_d;
         wdata_q    <= wdata_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         rd_pend_q  <= slot == SLOT_RD;
         rd_valid_q <= rd_pend_q;
         live_q     <= 1'b1;
      end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: random and directed traffic against a queue-based model with scoreboard monitor
module tb_vram_arbiter;
   localparam int AW = 12, DW = 8, CELLS = 2400, FD = 4;
   typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
   typedef struct {int k; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
   logic clk = 0, rst_n = 1;
   logic i_rd_req, i_wr_valid, i_clear_start, o_rd_valid, o_wr_ready, o_clear_busy, o_mem_we;
   logic [AW-1:0] i_rd_addr, i_wr_addr, o_mem_addr;
   logic [DW-1:0] i_wr_data, i_clear_data, o_rd_data, o_mem_wdata, i_mem_rdata;
   logic [DW-1:0] ram [4096];
   logic [DW-1:0] ref_mem [4096];
   wr_t m_q[$];
   op_t exp_op[$];
   logic [DW-1:0] exp_rd[$];
   bit m_run, mon_en, prev_rd;
   int m_caddr, n_chk = 0, n_fail = 0, n_we = 0;
   logic [DW-1:0] m_fill, last_rd;
   op_t mon_op;
   always #5 clk = ~clk;
   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CELLS(CELLS), .FIFO_DEPTH(FD)) dut (
      .i_pix_clk(clk), .i_reset_n(rst_n), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
      .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_wr_valid(i_wr_valid),
      .o_wr_ready(o_wr_ready), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_clear_start(i_clear_start), .i_clear_data(i_clear_data), .o_clear_busy(o_clear_busy),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
      .i_mem_rdata(i_mem_rdata)
   );
   always @(posedge clk) if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
   assign i_mem_rdata = ram[o_mem_addr];
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (!mon_en) begin
         prev_rd = 0;
         last_rd = 0;
      end else begin
         if (o_mem_we) n_we++;
         chk("rd_valid", o_rd_valid, prev_rd);
         if (prev_rd && exp_rd.size() > 0) last_rd = exp_rd.pop_front();
         chk("rd_data", o_rd_data, last_rd);
         prev_rd = 0;
         if (exp_op.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL op_queue: RAM cycle with no expected op at %0t", $time);
         end else begin
            mon_op = exp_op.pop_front();
            chk("mem_we", o_mem_we, mon_op.k == 2);
            if (mon_op.k != 0) chk("mem_addr", o_mem_addr, mon_op.a);
            if (mon_op.k == 2) chk("mem_wdata", o_mem_wdata, mon_op.d);
            prev_rd = mon_op.k == 1;
         end
      end
   end
   // one clock of stimulus; the model decides what the next edge must do
   task automatic cycle(bit rd, logic [AW-1:0] ra, bit wv, logic [AW-1:0] wa, logic [DW-1:0] wd,
                        bit cs, logic [DW-1:0] cd);
      op_t op;
      wr_t w;
      bit was_run, acc;
      @(negedge clk);
      #1;
      i_rd_req = rd; i_rd_addr = ra; i_wr_valid = wv; i_wr_addr = wa; i_wr_data = wd;
      i_clear_start = cs; i_clear_data = cd;
      chk("wr_ready", o_wr_ready, m_q.size() < FD);
      chk("clear_busy", o_clear_busy, m_run);
      acc = wv && m_q.size() < FD;
      was_run = m_run;
      op = '{0, '0, '0};
      if (rd) begin
         op = '{1, ra, '0};
         exp_rd.push_back(ref_mem[ra]);
      end else if (m_run) begin
         op = '{2, AW'(m_caddr), m_fill};
         ref_mem[m_caddr] = m_fill;
         m_caddr++;
         if (m_caddr == CELLS) m_run = 0;
      end else if (m_q.size() > 0) begin
         w = m_q.pop_front();
         op = '{2, w.a, w.d};
         ref_mem[w.a] = w.d;
      end
      if (!was_run && cs) begin
         m_run = 1;
         m_fill = cd;
         m_caddr = 0;
      end
      if (acc) m_q.push_back('{wa, wd});
      exp_op.push_back(op);
      mon_en = 1;
   endtask
   task automatic idle();
      cycle(0, '0, 0, '0, '0, 0, '0);
   endtask
   task automatic do_reset();
      mon_en = 0;
      rst_n = 0;
      i_rd_req = 0; i_wr_valid = 0; i_clear_start = 0;
      #1;
      chk("rst_mem_we", o_mem_we, 0);
      chk("rst_mem_addr", o_mem_addr, 0);
      chk("rst_mem_wdata", o_mem_wdata, 0);
      chk("rst_rd_valid", o_rd_valid, 0);
      chk("rst_rd_data", o_rd_data, 0);
      chk("rst_wr_ready", o_wr_ready, 0);
      chk("rst_busy", o_clear_busy, 0);
      exp_op.delete(); exp_rd.delete(); m_q.delete();
      m_run = 0; m_caddr = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4096; i++) ref_mem[i] = ram[i];
      #1 rst_n = 1;
      @(negedge clk);
      chk("rel_wr_ready", o_wr_ready, 1);
      chk("rel_busy", o_clear_busy, 0);
   endtask
   initial begin
      int n, we0;
      logic [DW-1:0] save;
      i_rd_req = 0; i_rd_addr = '0; i_wr_valid = 0; i_wr_addr = '0; i_wr_data = '0;
      i_clear_start = 0; i_clear_data = '0;
      for (int i = 0; i < 4096; i++) ram[i] = DW'($urandom);
      ram[5] = 8'h41;
      #2;
      do_reset();
      cycle(1, 12'h005, 0, '0, '0, 0, '0);
      idle();
      chk("t2_mem_addr", o_mem_addr, 12'h005);
      chk("t2_mem_we", o_mem_we, 0);
      idle();
      chk("t2_rd_valid", o_rd_valid, 1);
      chk("t2_rd_data", o_rd_data, 8'h41);
      for (int i = 0; i < 5; i++) cycle(1, AW'($urandom), 1, AW'(256 + i), DW'(160 + i), 0, '0);
      chk("t3_full_ready", o_wr_ready, 0);
      repeat (6) idle();
      repeat (3) cycle(1, AW'($urandom), 1, AW'($urandom), DW'($urandom), 0, '0);
      @(posedge clk);
      #2;
      do_reset();
      repeat (4) idle();
      save = ram[CELLS];
      we0 = n_we;
      cycle(0, '0, 0, '0, '0, 1, 8'h20);
      n = 0;
      while (m_run && n < 8000) begin
         cycle(n % 2 == 0, AW'($urandom), n == 100, 12'h010, 8'h7F, n == 500, 8'h55);
         n++;
      end
      chk("t4_clear_done", n < 8000, 1);
      repeat (4) idle();
      chk("t4_write_count", n_we - we0, CELLS + 1);
      chk("t4_first_cell", ram[0], 8'h20);
      chk("t4_last_cell", ram[CELLS-1], 8'h20);
      chk("t5_host_after_clear", ram[12'h010], 8'h7F);
      chk("t6_no_overrun", ram[CELLS], save);
      chk("t6_busy_low", o_clear_busy, 0);
      for (int i = 0; i < 4000; i++)
         cycle(($urandom % 2) == 1, AW'($urandom), ($urandom % 3) == 0, AW'($urandom),
               DW'($urandom), ($urandom % 700) == 0, DW'($urandom));
      n = 0;
      while ((m_run || m_q.size() > 0) && n < 8000) begin
         idle();
         n++;
      end
      chk("drain_done", n < 8000, 1);
      repeat (2) idle();
      @(negedge clk);
      #1;
      chk("exp_op_left", exp_op.size(), 0);
      chk("exp_rd_left", exp_rd.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
